id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one parameter, PERF_W, default 16: width of the performance counters.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  decode holds a valid instruction.
REQ-006 in_ready  out  1  stage can accept; driven from a register only.
REQ-007 in_ctrl  in  lc3b_control  control word from the decode control ROM.
REQ-008 in_pc  in  16  incremented PC of the instruction.
REQ-009 in_ir  in  16  instruction word.
REQ-010 in_sr1, in_sr2  in  16 each  register-file read data.
REQ-011 out_valid  out  1  EX-side entry is valid.
REQ-012 out_ready  in  1  EX consumes the entry this cycle.
REQ-013 out_ctrl, out_pc, out_ir, out_sr1, out_sr2  out  as inputs  EX-side entry.
REQ-014 flush  in  1  kill every instruction held in the stage (taken branch, JMP, JSR, TRAP).

Function
REQ-015 Storage SHALL be two entries, main and skid, each holding {ctrl, pc, ir, sr1, sr2, valid}; outputs SHALL come from main.
REQ-016 Accept SHALL mean in_valid && in_ready; transfer SHALL mean out_valid && out_ready.
REQ-017 in_ready SHALL be the registered value of !skid.valid.
REQ-018 On accept with main empty, or main being transferred in the same cycle with skid empty, the input SHALL load main. Latency: 1 cycle.
REQ-019 On accept while main is valid and not transferring, the input SHALL load skid.
REQ-020 On transfer with skid valid, skid SHALL move to main and skid SHALL empty; a simultaneous accept SHALL be impossible because in_ready=0.
REQ-021 Order SHALL be strict FIFO; no entry SHALL be dropped or duplicated unless flushed.
REQ-022 A held entry SHALL keep every output field stable while out_valid=1 and out_ready=0.
REQ-023 Flush SHALL take priority over all other events: both valid bits clear next cycle, any same-cycle accept is discarded, and in_ready SHALL be 1 the cycle after.
REQ-024 out_ctrl SHALL be sanitized combinationally whenever out_valid=0: load_regfile, load_cc, load_pc, read_memory and write_memory forced to 0; other fields pass unchanged.
REQ-025 Data fields of invalid entries are don't-care; control load/write bits SHALL never leave the stage asserted while out_valid=0.

Reset
REQ-026 Asserting reset, at any time including mid-transfer, SHALL immediately clear main.valid and skid.valid, set out_valid=0, and drive out_ctrl sanitized.
REQ-027 After reset the registered in_ready SHALL be 1, and data registers SHALL be 0.
REQ-028 Counters, when present, SHALL reset to 0.
REQ-029 Reset release SHALL require no extra idle cycles.

Configuration
REQ-030 When macro IDEX_PERF_EN is defined, the stage SHALL add outputs stall_cnt[PERF_W] and kill_cnt[PERF_W].
REQ-031 stall_cnt SHALL count cycles with out_valid && !out_ready.
REQ-032 kill_cnt SHALL add the number of valid entries (0-2) discarded by each flush.
REQ-033 Both counters SHALL saturate at all-ones.
REQ-034 When IDEX_PERF_EN is not defined, these ports and their logic SHALL be absent, and behaviour otherwise SHALL be identical.

Structure
REQ-035 The idex_entry_t struct and a sanitize_ctrl function SHALL be added to lc3b_types alongside lc3b_control and lc3b_word.
REQ-036 The counters SHALL be one sub-module, idex_perf_ctr, instantiated twice, only under IDEX_PERF_EN.

Verification
REQ-037 Empty stage, accept ADD (ctrl.load_regfile=1, pc=0x0012) -> next cycle out_valid=1, out_pc=0x0012, out_ctrl.load_regfile=1.
REQ-038 out_ready=0 and feed 2 instructions (pc 0x0002, 0x0004) -> in_ready=0 after the second; raise out_ready -> out_pc 0x0002 then 0x0004 on consecutive cycles.
REQ-039 Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl.write_memory=0, in_ready=1; with IDEX_PERF_EN, kill_cnt=2.
REQ-040 Stream STR (write_memory=1) with out_ready toggling 1,0,1,0 -> every instruction seen exactly once, in order; stall_cnt=2.
REQ-041 Assert reset mid-stream, asynchronously between edges -> out_valid=0 and sanitized out_ctrl before the next edge; in_ready=1 after the first edge.
REQ-042 Build without IDEX_PERF_EN, rerun REQ-038 -> identical waveform on all shared ports.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: control word, ID/EX pipeline entry, and the
// helper that strips side-effecting control bits from a bubble.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef struct packed {
        logic [3:0] opcode;
        logic [1:0] aluop;
        logic [1:0] pcmux_sel;
        logic       alumux_sel;
        logic       load_regfile;
        logic       load_cc;
        logic       load_pc;
        logic       read_memory;
        logic       write_memory;
    } lc3b_control;

    typedef struct packed {
        lc3b_control ctrl;
        lc3b_word    pc;
        lc3b_word    ir;
        lc3b_word    sr1;
        lc3b_word    sr2;
        logic        valid;
    } idex_entry_t;

    // A bubble must never update architectural state or touch memory.
    function automatic lc3b_control sanitize_ctrl(input lc3b_control c);
        lc3b_control s;
        s              = c;
        s.load_regfile = 1'b0;
        s.load_cc      = 1'b0;
        s.load_pc      = 1'b0;
        s.read_memory  = 1'b0;
        s.write_memory = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/idex_perf_ctr.sv
// Saturating event counter for the ID/EX stage; adds 0..3 per cycle.
module idex_perf_ctr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   sum;

    always_comb begin
        sum   = {1'b0, cnt_q} + (W+1)'(inc);
        cnt_d = sum[W] ? '1 : sum[W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register built as a two-entry skid buffer with flush.
// Optional stall/kill counters are enabled by defining IDEX_PERF_EN.
module id_ex_stage
    import lc3b_types::*;
#(
    parameter int PERF_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  lc3b_control in_ctrl,
    input  lc3b_word    in_pc,
    input  lc3b_word    in_ir,
    input  lc3b_word    in_sr1,
    input  lc3b_word    in_sr2,
    output logic        out_valid,
    input  logic        out_ready,
    output lc3b_control out_ctrl,
    output lc3b_word    out_pc,
    output lc3b_word    out_ir,
    output lc3b_word    out_sr1,
    output lc3b_word    out_sr2,
    input  logic        flush
`ifdef IDEX_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] kill_cnt
`endif
);

    idex_entry_t main_q, main_d;
    idex_entry_t skid_q, skid_d;
    idex_entry_t in_entry;
    logic        ready_q, ready_d;
    logic        accept, xfer;

    always_comb begin
        in_entry = '{ctrl: in_ctrl, pc: in_pc, ir: in_ir, sr1: in_sr1, sr2: in_sr2, valid: 1'b1};
        accept   = in_valid && ready_q;
        xfer     = main_q.valid && out_ready;
        main_d   = main_q;
        skid_d   = skid_q;
        if (flush) begin
            main_d.valid = 1'b0;
            skid_d.valid = 1'b0;
        end else if (!main_q.valid || xfer) begin
            // in_ready is low whenever skid is occupied, so skid and input never compete.
            if (skid_q.valid) begin
                main_d       = skid_q;
                skid_d.valid = 1'b0;
            end else if (accept) begin
                main_d = in_entry;
            end else begin
                main_d.valid = 1'b0;
            end
        end else if (accept) begin
            skid_d = in_entry;
        end
        ready_d = !skid_d.valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_q.valid;
    assign out_ctrl  = main_q.valid ? main_q.ctrl : sanitize_ctrl(main_q.ctrl);
    assign out_pc    = main_q.pc;
    assign out_ir    = main_q.ir;
    assign out_sr1   = main_q.sr1;
    assign out_sr2   = main_q.sr2;

`ifdef IDEX_PERF_EN
    logic [1:0] stall_inc, kill_inc;

    always_comb begin
        stall_inc = {1'b0, main_q.valid && !out_ready};
        kill_inc  = flush ? ({1'b0, main_q.valid} + {1'b0, skid_q.valid}) : 2'd0;
    end

    idex_perf_ctr #(.W(PERF_W)) u_stall_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .cnt   (stall_cnt)
    );

    idex_perf_ctr #(.W(PERF_W)) u_kill_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (kill_inc),
        .cnt   (kill_cnt)
    );
`else
    // Counter width is meaningless without the counters; keep the parameter referenced.
    if (PERF_W < 1) begin : g_perf_w_unused
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a FIFO-of-instructions model with occupancy
// count predicts in_ready/out_valid; a negedge monitor checks every output entry.
module tb_id_ex_stage;
    import lc3b_types::*;

    localparam int PERF_W = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    lc3b_control in_ctrl = '0;
    lc3b_word    in_pc = '0, in_ir = '0, in_sr1 = '0, in_sr2 = '0;
    logic        in_ready, out_valid;
    lc3b_control out_ctrl;
    lc3b_word    out_pc, out_ir, out_sr1, out_sr2;
`ifdef IDEX_PERF_EN
    logic [PERF_W-1:0] stall_cnt, kill_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(.PERF_W(PERF_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_pc     (in_pc),
        .in_ir     (in_ir),
        .in_sr1    (in_sr1),
        .in_sr2    (in_sr2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_pc    (out_pc),
        .out_ir    (out_ir),
        .out_sr1   (out_sr1),
        .out_sr2   (out_sr2),
        .flush     (flush)
`ifdef IDEX_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .kill_cnt  (kill_cnt)
`endif
    );

    idex_entry_t exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          occ = 0;
    int unsigned stall_m = 0;
    int unsigned kill_m = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [4:0] side_bits(input lc3b_control c);
        return {c.load_regfile, c.load_cc, c.load_pc, c.read_memory, c.write_memory};
    endfunction

    function automatic lc3b_control rand_ctrl();
        logic [31:0] r;
        r = $urandom;
        return r[$bits(lc3b_control)-1:0];
    endfunction

    function automatic idex_entry_t mk(input lc3b_control c, input lc3b_word pc);
        idex_entry_t e;
        e.ctrl  = c;
        e.pc    = pc;
        e.ir    = 16'($urandom);
        e.sr1   = 16'($urandom);
        e.sr2   = 16'($urandom);
        e.valid = 1'b1;
        return e;
    endfunction

    // Monitor: every presented entry must be the oldest outstanding instruction.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    chk("out_ctrl", 64'(out_ctrl), 64'(exp_q[0].ctrl));
                    chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
                    chk("out_ir", 64'(out_ir), 64'(exp_q[0].ir));
                    chk("out_sr1", 64'(out_sr1), 64'(exp_q[0].sr1));
                    chk("out_sr2", 64'(out_sr2), 64'(exp_q[0].sr2));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("bubble_sanitized", 64'(side_bits(out_ctrl)), 64'd0);
            end
        end
    end

    // One clock of stimulus; entered and left at posedge+1.
    task automatic step(input logic iv, input idex_entry_t e, input logic ordy,
                        input logic fl, output logic acc);
        int pre;
        in_valid  = iv;
        in_ctrl   = e.ctrl;
        in_pc     = e.pc;
        in_ir     = e.ir;
        in_sr1    = e.sr1;
        in_sr2    = e.sr2;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        #1;
        pre = occ;
        chk("in_ready", 64'(in_ready), 64'(pre < 2));
        chk("out_valid", 64'(out_valid), 64'(pre > 0));
        acc = iv && (pre < 2) && !fl;
        if (pre > 0 && !ordy && stall_m != 32'(2**PERF_W - 1)) stall_m++;
        if (fl) begin
            kill_m = (kill_m + pre > 32'(2**PERF_W - 1)) ? 32'(2**PERF_W - 1) : kill_m + pre;
            occ = 0;
            exp_q.delete();
        end else begin
            if (pre > 0 && ordy) occ--;
            if (acc) begin
                exp_q.push_back(e);
                occ++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lc3b_control add_c, str_c;
        idex_entry_t str_e[4];
        logic        acc, iv, ordy, fl;
        int          pend, k;
        logic [PERF_W-1:0] s0;

        add_c = '0; add_c.opcode = 4'b0001; add_c.load_regfile = 1'b1; add_c.load_cc = 1'b1;
        str_c = '0; str_c.opcode = 4'b0111; str_c.write_memory = 1'b1;
        s0 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_sr1", 64'(out_sr1), 64'd0);
        chk("rst_sanitized", 64'(side_bits(out_ctrl)), 64'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Single ADD, one-cycle latency
        step(1'b1, mk(add_c, 16'h0012), 1'b0, 1'b0, acc);
        chk("add_out_valid", 64'(out_valid), 64'd1);
        chk("add_out_pc", 64'(out_pc), 64'h0012);
        chk("add_load_regfile", 64'(out_ctrl.load_regfile), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b1, 1'b0, acc);

        // Two entries while EX stalls, then drain in order
        step(1'b1, mk(add_c, 16'h0002), 1'b0, 1'b0, acc);
        step(1'b1, mk(add_c, 16'h0004), 1'b0, 1'b0, acc);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0, acc);
        chk("drain_second_pc", 64'(out_pc), 64'h0004);
        step(1'b0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b1, 1'b0, acc);

        // Flush with both entries full and a concurrent input
        step(1'b1, mk(str_c, 16'h0020), 1'b0, 1'b0, acc);
        step(1'b1, mk(str_c, 16'h0022), 1'b0, 1'b0, acc);
        step(1'b1, mk(str_c, 16'h0024), 1'b0, 1'b1, acc);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_write_memory", 64'(out_ctrl.write_memory), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
`ifdef IDEX_PERF_EN
        chk("flush_kill_cnt", 64'(kill_cnt), 64'(kill_m));
`endif
        step(1'b0, '0, 1'b1, 1'b0, acc);

        // STR stream with out_ready toggling 1,0,1,0
        for (int i = 0; i < 4; i++) str_e[i] = mk(str_c, 16'(16'h0100 + 2*i));
`ifdef IDEX_PERF_EN
        s0 = stall_cnt;
`endif
        pend = 0;
        k = 0;
        while (pend < 4 && k < 20) begin
            ordy = (k < 4) ? ((k % 2) == 0) : 1'b1;
            step(1'b1, str_e[pend], ordy, 1'b0, acc);
            if (acc) pend++;
            k++;
        end
        chk("str_all_accepted", 64'(pend), 64'd4);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0, acc);
        chk("str_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef IDEX_PERF_EN
        chk("str_stall_delta", 64'(stall_cnt - s0), 64'd2);
`endif

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 1500; i++) begin
            fl   = ($urandom_range(0, 24) == 0);
            ordy = fl ? 1'b0 : ($urandom_range(0, 2) != 0);
            iv   = ($urandom_range(0, 3) != 0);
            step(iv, mk(rand_ctrl(), 16'($urandom)), ordy, fl, acc);
        end
`ifdef IDEX_PERF_EN
        chk("rand_stall_cnt", 64'(stall_cnt), 64'(stall_m));
        chk("rand_kill_cnt", 64'(kill_cnt), 64'(kill_m));
`endif

        // Asynchronous reset mid-transfer
        step(1'b1, mk(str_c, 16'h0200), 1'b0, 1'b0, acc);
        step(1'b1, mk(str_c, 16'h0202), 1'b0, 1'b0, acc);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #3 reset = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_sanitized", 64'(side_bits(out_ctrl)), 64'd0);
        exp_q.delete();
        occ = 0;
        stall_m = 0;
        kill_m = 0;
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 40; i++) begin
            ordy = ($urandom_range(0, 1) != 0);
            step(1'b1, mk(rand_ctrl(), 16'($urandom)), ordy, 1'b0, acc);
        end
        repeat (4) step(1'b0, '0, 1'b1, 1'b0, acc);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef IDEX_PERF_EN
        chk("final_stall_cnt", 64'(stall_cnt), 64'(stall_m));
        chk("final_kill_cnt", 64'(kill_cnt), 64'(kill_m));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
